// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locking arbiter for the write port of one FIFO.
// One IDLE bubble separates every hand-over between producers.
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   din_flat,
    output logic [NUM_REQ-1:0]         ack,
    output logic [NUM_REQ-1:0]         grant,
    input  logic                       fifo_full,
    output logic                       fifo_wr_en,
    output logic [WIDTH-1:0]           fifo_din,
    output logic                       busy
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IW-1:0]      owner_q, owner_d;
    logic [IW-1:0]      last_q, last_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic [IW-1:0]      win;
    logic               win_vld;
    logic               beat;
    logic               last_beat;
    int                 idx;

    // Search upward from the slot after the last winner, wrapping.
    always_comb begin
        win     = last_q;
        win_vld = 1'b0;
        idx     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_q) + k) % NUM_REQ;
            if (!win_vld && req[idx]) begin
                win     = IW'(idx);
                win_vld = 1'b1;
            end
        end
    end

    assign busy      = (state_q == GRANT);
    assign beat      = busy & req[owner_q] & ~fifo_full;
    assign last_beat = beat & (cnt_q == CW'(MAX_BURST - 1));

    assign grant      = grant_q;
    assign fifo_wr_en = beat;
    assign ack        = grant_q & {NUM_REQ{beat}};
    assign fifo_din   = busy ? din_flat[owner_q*WIDTH +: WIDTH]
                             : '0;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d      = GRANT;
                    grant_d      = '0;
                    grant_d[win] = 1'b1;
                    owner_d      = win;
                    last_d       = win;
                    cnt_d        = '0;
                end
            end
            GRANT: begin
                if (!req[owner_q] || last_beat) begin
                    state_d = IDLE;
                    grant_d = '0;
                    cnt_d   = '0;
                end else if (beat) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            last_q  <= IW'(NUM_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: vector table, directed
// corner sequences and randomized traffic against a reference model.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MB = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] din_flat = '0;
    logic           fifo_full = 1'b0;
    logic [N-1:0]   ack;
    logic [N-1:0]   grant;
    logic           fifo_wr_en;
    logic [W-1:0]   fifo_din;
    logic           busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [N-1:0] s_grant, s_ack;
    logic         s_wr, s_busy;
    logic [W-1:0] s_din;

    int m_owner, m_beats, m_last;

    fifo_wr_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .din_flat   (din_flat),
        .ack        (ack),
        .grant      (grant),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_din   (fifo_din),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] req;
        logic         full;
        logic [W-1:0] d0;
        logic [N-1:0] g;
        logic [N-1:0] a;
        logic         w;
        logic [W-1:0] o;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_beats = 0;
        m_last  = N - 1;
    endtask

    task automatic model_step();
        bit f;
        bit bt;
        f = 1'b0;
        if (!rst_n) begin
            model_reset();
        end else if (m_owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                int i;
                i = (m_last + k) % N;
                if (!f && req[i]) begin
                    f       = 1'b1;
                    m_owner = i;
                    m_last  = i;
                    m_beats = 0;
                end
            end
        end else begin
            bt = req[m_owner] && !fifo_full;
            if (!req[m_owner]) begin
                m_owner = -1;
            end else if (bt) begin
                m_beats++;
                if (m_beats == MB) m_owner = -1;
            end
        end
    endtask

    task automatic check_model();
        logic [N-1:0] eg, ea;
        logic         ew, eb;
        logic [W-1:0] ed;
        eg = '0; ea = '0; ew = 1'b0; eb = 1'b0; ed = '0;
        if (m_owner >= 0) begin
            eg[m_owner] = 1'b1;
            ew = req[m_owner] && !fifo_full;
            ea = ew ? eg : '0;
            ed = din_flat[m_owner*W +: W];
            eb = 1'b1;
        end
        chk("m_grant", 32'(s_grant), 32'(eg));
        chk("m_ack", 32'(s_ack), 32'(ea));
        chk("m_wr_en", 32'(s_wr), 32'(ew));
        chk("m_din", 32'(s_din), 32'(ed));
        chk("m_busy", 32'(s_busy), 32'(eb));
    endtask

    task automatic tick(input bit use_model);
        @(negedge clk);
        s_grant = grant;
        s_ack   = ack;
        s_wr    = fifo_wr_en;
        s_din   = fifo_din;
        s_busy  = busy;
        if (use_model) check_model();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req       = '0;
        fifo_full = 1'b0;
        din_flat  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic int owner_of(input logic [N-1:0] oh);
        int r;
        r = -1;
        for (int i = 0; i < N; i++) if (oh[i]) r = i;
        return r;
    endfunction

    initial begin
        int w20;
        int q_own[$];
        int p1w;
        logic [N-1:0] starts[$];
        logic [N-1:0] prev_g;

        tbl[0] = '{4'b0001, 1'b0, 8'h10, 4'b0000, 4'b0000, 1'b0, 8'h00};
        tbl[1] = '{4'b0001, 1'b0, 8'h10, 4'b0001, 4'b0001, 1'b1, 8'h10};
        tbl[2] = '{4'b0001, 1'b0, 8'h11, 4'b0001, 4'b0001, 1'b1, 8'h11};
        tbl[3] = '{4'b0001, 1'b0, 8'h12, 4'b0001, 4'b0001, 1'b1, 8'h12};
        tbl[4] = '{4'b0001, 1'b0, 8'h13, 4'b0001, 4'b0001, 1'b1, 8'h13};
        tbl[5] = '{4'b0001, 1'b0, 8'h14, 4'b0000, 4'b0000, 1'b0, 8'h00};
        tbl[6] = '{4'b0001, 1'b0, 8'h14, 4'b0001, 4'b0001, 1'b1, 8'h14};
        tbl[7] = '{4'b0001, 1'b0, 8'h15, 4'b0001, 4'b0001, 1'b1, 8'h15};
        tbl[8] = '{4'b0000, 1'b0, 8'h00, 4'b0001, 4'b0000, 1'b0, 8'h00};
        tbl[9] = '{4'b0000, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0, 8'h00};

        do_reset();
        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_wr_en", 32'(fifo_wr_en), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_din", 32'(fifo_din), 0);

        for (int i = 0; i < 10; i++) begin
            req       = tbl[i].req;
            fifo_full = tbl[i].full;
            din_flat  = {24'h0, tbl[i].d0};
            tick(1'b0);
            chk($sformatf("tbl%0d_grant", i), 32'(s_grant), 32'(tbl[i].g));
            chk($sformatf("tbl%0d_ack", i), 32'(s_ack), 32'(tbl[i].a));
            chk($sformatf("tbl%0d_wr", i), 32'(s_wr), 32'(tbl[i].w));
            chk($sformatf("tbl%0d_din", i), 32'(s_din), 32'(tbl[i].o));
        end

        // all four producers streaming
        do_reset();
        req = 4'b1111;
        w20 = 0;
        for (int c = 0; c < 22; c++) begin
            din_flat = $urandom;
            tick(1'b1);
            if (s_wr) begin
                if (c < 20) w20++;
                q_own.push_back(owner_of(s_ack));
            end
        end
        chk("rr_writes20", w20, 16);
        chk("rr_nwrites", q_own.size(), 17);
        for (int k = 0; k < 17 && k < q_own.size(); k++)
            chk($sformatf("rr_owner%0d", k), q_own[k],
                (k < 16) ? k / 4 : 0);

        // producer 2 stalled by full after two beats
        do_reset();
        req = 4'b0100;
        for (int c = 0; c < 12; c++) begin
            fifo_full = (c >= 3 && c <= 7);
            din_flat  = $urandom;
            tick(1'b1);
            if (c == 1 || c == 2 || c == 8 || c == 9)
                chk($sformatf("full_beat_c%0d", c), 32'(s_wr), 1);
            if (c >= 3 && c <= 7) begin
                chk($sformatf("full_grant_c%0d", c), 32'(s_grant), 4);
                chk($sformatf("full_wr_c%0d", c), 32'(s_wr), 0);
                chk($sformatf("full_ack_c%0d", c), 32'(s_ack), 0);
            end
            if (c == 10) chk("full_release", 32'(s_grant), 0);
        end

        // producer 1 drops after one beat, producer 3 waiting
        do_reset();
        p1w = 0;
        for (int c = 0; c < 6; c++) begin
            unique case (c)
                0: req = 4'b0010;
                1: req = 4'b1010;
                default: req = 4'b1000;
            endcase
            din_flat = $urandom;
            tick(1'b1);
            if (s_ack[1]) p1w++;
            if (c == 2) chk("drop_hold", 32'(s_grant), 2);
            if (c == 3) chk("drop_bubble", 32'(s_grant), 0);
            if (c == 4) chk("drop_next", 32'(s_grant), 8);
        end
        chk("drop_p1_writes", p1w, 1);

        // asynchronous reset mid-burst
        do_reset();
        req = 4'b0001;
        repeat (3) tick(1'b1);
        chk("pre_rst_wr", 32'(fifo_wr_en), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_grant", 32'(grant), 0);
        chk("arst_wr", 32'(fifo_wr_en), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_ack", 32'(ack), 0);
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        req   = 4'b0011;
        tick(1'b1);
        tick(1'b1);
        chk("arst_first", 32'(s_grant), 1);

        // fairness: producer 3 asks once while 0 streams
        do_reset();
        req    = 4'b0001;
        prev_g = '0;
        for (int c = 0; c < 15; c++) begin
            if (c == 2) req[3] = 1'b1;
            din_flat = $urandom;
            tick(1'b1);
            if (s_grant != 0 && prev_g == 0) starts.push_back(s_grant);
            prev_g = s_grant;
            if (s_ack[3]) req[3] = 1'b0;
        end
        chk("fair_nstarts", starts.size(), 4);
        if (starts.size() >= 3) begin
            chk("fair_start0", 32'(starts[0]), 1);
            chk("fair_start1", 32'(starts[1]), 8);
            chk("fair_start2", 32'(starts[2]), 1);
        end

        // randomized traffic against the model
        do_reset();
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++)
                req[i] = (($urandom % 4) != 0);
            fifo_full = (c % 200 < 100) ? (($urandom % 4) == 0)
                                        : (($urandom % 2) == 0);
            din_flat  = $urandom;
            tick(1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
